// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 panel-side receiver.
// Pin bundle, receiver state encoding and rgb lane ordering.
package hub75_pkg;

  localparam int ROW_W = 5;
  localparam int RGB_W = 6;

  // bit positions within pin_rgb = {b1,g1,r1,b0,g0,r0}
  localparam int RGB_R0 = 0;
  localparam int RGB_G0 = 1;
  localparam int RGB_B0 = 2;
  localparam int RGB_R1 = 3;
  localparam int RGB_G1 = 4;
  localparam int RGB_B1 = 5;

  typedef struct packed {
    logic             clk;
    logic             stb;
    logic             oe;
    logic [ROW_W-1:0] addr;
    logic [RGB_W-1:0] rgb;
  } hub75_pins_t;

  typedef enum logic {
    RX_IDLE,
    RX_STREAM
  } rx_state_e;

endpackage

// File: rtl/hub75_pin_sync.sv
// Two-flop synchronizer for the whole HUB75 pin bundle, plus rising-edge
// pulses for the serial clock and latch, registered alongside the synced pins.
module hub75_pin_sync
  import hub75_pkg::*;
(
  input  logic        display_clock,
  input  logic        reset,
  input  hub75_pins_t pins,
  output hub75_pins_t synced,
  output logic        clk_rise,
  output logic        stb_rise
);

  hub75_pins_t s1;
  hub75_pins_t s2;

  // synced is the third register: edges compare stage 2 against it, so the
  // pulse and the synced data it refers to leave this block on the same cycle
  always_ff @(posedge display_clock) begin
    if (reset) begin
      s1       <= '0;
      s2       <= '0;
      synced   <= '0;
      clk_rise <= 1'b0;
      stb_rise <= 1'b0;
    end else begin
      s1       <= pins;
      s2       <= s1;
      synced   <= s2;
      clk_rise <= s2.clk & ~synced.clk;
      stb_rise <= s2.stb & ~synced.stb;
    end
  end

endmodule

// File: rtl/hub75_rx.sv
// HUB75 panel-side receiver: rebuilds each latched line as a tagged pixel stream.
// Optional OE-active cycle measurement under HUB75_RX_OE_MEASURE_EN.
//
// state     | meaning
// RX_IDLE   | no line pending, next latch is captured
// RX_STREAM | emitting held line one column per accepted beat
module hub75_rx
  import hub75_pkg::*;
#(
  parameter int COLS   = 128,
  parameter int PLANES = 7,
  parameter int OVR_W  = 8
) (
  input  logic                    display_clock,
  input  logic                    reset,
  input  logic                    pin_clk,
  input  logic                    pin_stb,
  input  logic                    pin_oe,
  input  logic [ROW_W-1:0]        pin_addr,
  input  logic [RGB_W-1:0]        pin_rgb,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ROW_W-1:0]        out_row,
  output logic [2:0]              out_plane,
  output logic [$clog2(COLS)-1:0] out_col,
  output logic [RGB_W-1:0]        out_rgb,
  output logic [OVR_W-1:0]        overrun_cnt,
  output logic [15:0]             oe_cycles
);

  localparam int               COL_W      = $clog2(COLS);
  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(COLS - 1);
  localparam logic [2:0]       LAST_PLANE = 3'(PLANES - 1);

  hub75_pins_t pins_raw;
  hub75_pins_t synced;
  logic        clk_rise;
  logic        stb_rise;

  assign pins_raw = '{clk: pin_clk, stb: pin_stb, oe: pin_oe, addr: pin_addr, rgb: pin_rgb};

  hub75_pin_sync u_sync (
    .display_clock(display_clock),
    .reset        (reset),
    .pins         (pins_raw),
    .synced       (synced),
    .clk_rise     (clk_rise),
    .stb_rise     (stb_rise)
  );

  logic unused_pins;
  assign unused_pins = ^{synced.clk, synced.stb, synced.oe};

  logic [RGB_W-1:0] sh      [COLS];
  logic [RGB_W-1:0] sh_next [COLS];
  logic [RGB_W-1:0] hold    [COLS];

  // a latch on the same cycle as a shift must see the new bit
  always_comb begin
    sh_next = sh;
    if (clk_rise) begin
      sh_next[0] = synced.rgb;
      for (int i = 1; i < COLS; i++) sh_next[i] = sh[i-1];
    end
  end

  always_ff @(posedge display_clock) begin
    if (reset) begin
      for (int i = 0; i < COLS; i++) sh[i] <= '0;
    end else begin
      sh <= sh_next;
    end
  end

  logic [ROW_W-1:0] last_addr;
  logic             first_latch;
  logic [2:0]       plane_q;
  logic [2:0]       plane_next;

  always_comb begin
    plane_next = plane_q;
    if (first_latch || (synced.addr != last_addr)) plane_next = 3'd0;
    else if (plane_q != LAST_PLANE)                plane_next = plane_q + 3'd1;
  end

  // plane tracking follows every latch, dropped or not
  always_ff @(posedge display_clock) begin
    if (reset) begin
      last_addr   <= '0;
      first_latch <= 1'b1;
      plane_q     <= 3'd0;
    end else if (stb_rise) begin
      last_addr   <= synced.addr;
      first_latch <= 1'b0;
      plane_q     <= plane_next;
    end
  end

  rx_state_e state_q;
  rx_state_e state_d;
  logic      accept;
  logic      advance;

  always_ff @(posedge display_clock) begin
    if (reset) state_q <= RX_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    advance   = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (stb_rise) begin
          accept  = 1'b1;
          state_d = RX_STREAM;
        end
      end
      RX_STREAM: begin
        out_valid = 1'b1;
        if (out_ready) begin
          advance = 1'b1;
          if (out_col == LAST_COL) state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge display_clock) begin
    if (reset) begin
      for (int c = 0; c < COLS; c++) hold[c] <= '0;
      out_row     <= '0;
      out_plane   <= 3'd0;
      out_col     <= '0;
      overrun_cnt <= '0;
    end else begin
      if (accept) begin
        for (int c = 0; c < COLS; c++) hold[c] <= sh_next[COLS-1-c];
        out_row   <= synced.addr;
        out_plane <= plane_next;
        out_col   <= '0;
      end else if (advance) begin
        out_col <= out_col + 1'b1;
      end
      if (stb_rise && (state_q == RX_STREAM) && (overrun_cnt != '1))
        overrun_cnt <= overrun_cnt + 1'b1;
    end
  end

  assign out_rgb = hold[out_col];

`ifdef HUB75_RX_OE_MEASURE_EN
  logic [15:0] oe_cnt;

  always_ff @(posedge display_clock) begin
    if (reset) begin
      oe_cnt    <= 16'd0;
      oe_cycles <= 16'd0;
    end else if (accept) begin
      oe_cycles <= oe_cnt;
      oe_cnt    <= 16'd0;
    end else if (!synced.oe && (oe_cnt != 16'hffff)) begin
      oe_cnt <= oe_cnt + 16'd1;
    end
  end
`else
  assign oe_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_hub75_rx.sv
// Self-checking bench for hub75_rx: chain/plane reference model, table of
// latch vectors, hand sequences for stall, overrun, mid-line reset and OE.
module tb_hub75_rx;
  import hub75_pkg::*;

  localparam int COLS   = 128;
  localparam int PLANES = 7;

  logic       display_clock = 1'b0;
  logic       reset;
  logic       pin_clk, pin_stb, pin_oe;
  logic [4:0] pin_addr;
  logic [5:0] pin_rgb;
  logic       out_valid, out_ready;
  logic [4:0] out_row;
  logic [2:0] out_plane;
  logic [6:0] out_col;
  logic [5:0] out_rgb;
  logic [7:0] overrun_cnt;
  logic [15:0] oe_cycles;

  always #5 display_clock = ~display_clock;

  hub75_rx #(.COLS(COLS), .PLANES(PLANES), .OVR_W(8)) dut (
    .display_clock(display_clock),
    .reset        (reset),
    .pin_clk      (pin_clk),
    .pin_stb      (pin_stb),
    .pin_oe       (pin_oe),
    .pin_addr     (pin_addr),
    .pin_rgb      (pin_rgb),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_row      (out_row),
    .out_plane    (out_plane),
    .out_col      (out_col),
    .out_rgb      (out_rgb),
    .overrun_cnt  (overrun_cnt),
    .oe_cycles    (oe_cycles)
  );

  typedef struct packed {
    logic [4:0]          row;
    logic [2:0]          plane;
    logic [COLS*6-1:0]   pix;
  } line_t;

  typedef struct {
    logic [4:0] addr;
    int         npix;
    int         exp_plane;
  } vec_t;

  line_t      exp_q[$];
  logic [5:0] chain[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         mon_col  = 0;
  int         n_lines  = 0;
  logic [2:0] last_plane_seen;
  logic [5:0] line_first_rgb, line_last_rgb;
  int         m_plane;
  logic [4:0] m_addr;
  bit         m_first;
  int         m_ovr;
  bit         rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge display_clock);
      #2;
    end
  endtask

  // reference: a chain of the last COLS shifted values, oldest first
  task automatic model_reset();
    chain.delete();
    repeat (COLS) chain.push_back(6'd0);
    exp_q.delete();
    m_first = 1'b1;
    m_plane = 0;
    m_addr  = '0;
    m_ovr   = 0;
  endtask

  function automatic logic [COLS*6-1:0] chain_pix();
    logic [COLS*6-1:0] p;
    for (int c = 0; c < COLS; c++) p[c*6 +: 6] = chain[c];
    return p;
  endfunction

  task automatic shift_pix(input logic [5:0] v);
    pin_rgb = v;
    tick(2);
    pin_clk = 1'b1;
    tick(2);
    pin_clk = 1'b0;
    chain.push_back(v);
    void'(chain.pop_front());
  endtask

  task automatic strobe(input logic [4:0] addr, input bit measure);
    int lat;
    line_t ln;
    lat = 0;
    if (m_first || addr != m_addr) m_plane = 0;
    else if (m_plane < PLANES - 1) m_plane++;
    m_addr  = addr;
    m_first = 1'b0;
    if (exp_q.size() != 0) begin
      if (m_ovr < 255) m_ovr++;
    end else begin
      ln.row   = addr;
      ln.plane = 3'(m_plane);
      ln.pix   = chain_pix();
      exp_q.push_back(ln);
    end
    pin_addr = addr;
    pin_stb  = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge display_clock);
      #1;
      if (lat == 0 && out_valid) lat = k;
      if (k == 2) pin_stb = 1'b0;
    end
    #1;
    if (measure) check("stb_to_valid_latency", lat, 4);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 5000) begin
      tick(1);
      t++;
    end
    if (t >= 5000) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d lines still expected", exp_q.size());
    end
  endtask

  task automatic wait_col(input int target);
    int t;
    t = 0;
    while (mon_col < target && t < 2000) begin
      @(negedge display_clock);
      t++;
    end
    if (t >= 2000) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_col_timeout: col %0d target %0d", mon_col, target);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    model_reset();
  endtask

  always @(negedge display_clock) begin
    if (reset) begin
      mon_col = 0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: col %0d row %0d", out_col, out_row);
      end else begin
        check("beat_row",   out_row,   exp_q[0].row);
        check("beat_plane", out_plane, exp_q[0].plane);
        check("beat_col",   out_col,   mon_col);
        check("beat_rgb",   out_rgb,   exp_q[0].pix[mon_col*6 +: 6]);
        if (out_ready) begin
          if (mon_col == 0)        line_first_rgb = out_rgb;
          if (mon_col == COLS - 1) line_last_rgb  = out_rgb;
          mon_col++;
          if (mon_col == COLS) begin
            last_plane_seen = out_plane;
            mon_col = 0;
            n_lines++;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  always @(posedge display_clock) begin
    if (rand_ready) begin
      #2;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    int   lines_before;
    logic [6:0] frozen_col;

    vecs[0] = '{5'd3, 0, 0};
    vecs[1] = '{5'd3, 0, 1};
    vecs[2] = '{5'd3, 4, 2};
    vecs[3] = '{5'd3, 0, 3};
    vecs[4] = '{5'd3, 0, 4};
    vecs[5] = '{5'd3, 1, 5};
    vecs[6] = '{5'd3, 0, 6};
    vecs[7] = '{5'd4, 0, 0};
    vecs[8] = '{5'd4, 2, 1};
    vecs[9] = '{5'd3, 0, 0};

    reset = 1'b1;
    pin_clk = 1'b0; pin_stb = 1'b0; pin_oe = 1'b1;
    pin_addr = '0; pin_rgb = '0;
    out_ready = 1'b1;
    model_reset();
    tick(3);
    check("rst_valid",   out_valid,   0);
    check("rst_col",     out_col,     0);
    check("rst_row",     out_row,     0);
    check("rst_plane",   out_plane,   0);
    check("rst_rgb",     out_rgb,     0);
    check("rst_overrun", overrun_cnt, 0);
    check("rst_oe",      oe_cycles,   0);
    reset = 1'b0;
    tick(2);

    // full line, rgb = column index
    for (int c = 0; c < COLS; c++) shift_pix(6'(c));
    strobe(5'd3, 1'b1);
    wait_drain();
    check("first_line_plane", last_plane_seen, 0);
    check("first_line_col127", line_last_rgb, 6'd63);

    // plane sequencing table
    do_reset();
    for (int i = 0; i < 10; i++) begin
      for (int p = 0; p < vecs[i].npix; p++) shift_pix(6'($urandom_range(0, 63)));
      strobe(vecs[i].addr, 1'b0);
      wait_drain();
      check("table_plane", last_plane_seen, vecs[i].exp_plane);
    end

    // chain longer than COLS: oldest two fall off
    do_reset();
    for (int i = 1; i <= 130; i++) shift_pix(6'(i));
    strobe(5'd7, 1'b0);
    wait_drain();
    check("overflow_col0",   line_first_rgb, 6'd3);
    check("overflow_col127", line_last_rgb,  6'd2);

    // stall mid-line with a dropped latch inside the stall
    for (int c = 0; c < COLS; c++) shift_pix(6'($urandom_range(0, 63)));
    lines_before = n_lines;
    strobe(5'd2, 1'b0);
    wait_col(40);
    @(posedge display_clock); #2;
    out_ready = 1'b0;
    tick(3);
    frozen_col = out_col;
    strobe(5'd2, 1'b0);
    tick(10);
    check("stall_col_frozen", out_col, frozen_col);
    check("stall_valid_held", out_valid, 1);
    out_ready = 1'b1;
    wait_drain();
    check("stall_overrun", overrun_cnt, 1);
    check("stall_overrun_model", overrun_cnt, m_ovr);
    check("stall_one_line", n_lines - lines_before, 1);

    // reset in the middle of a line
    for (int c = 0; c < 20; c++) shift_pix(6'($urandom_range(1, 63)));
    strobe(5'd9, 1'b0);
    wait_col(50);
    @(posedge display_clock); #2;
    reset = 1'b1;
    model_reset();
    @(posedge display_clock); #1;
    check("midrst_valid",   out_valid,   0);
    check("midrst_col",     out_col,     0);
    check("midrst_row",     out_row,     0);
    check("midrst_overrun", overrun_cnt, 0);
    check("midrst_rgb",     out_rgb,     0);
    #1;
    reset = 1'b0;
    tick(2);
    strobe(5'd9, 1'b0);
    wait_drain();
    check("post_rst_plane", last_plane_seen, 0);
    check("post_rst_data",  line_first_rgb | line_last_rgb, 0);

    // randomized lines, random backpressure, occasional overlapping latch
    rand_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      int npix;
      logic [4:0] a;
      npix = $urandom_range(0, 140);
      a    = 5'($urandom_range(0, 1));
      for (int p = 0; p < npix; p++) shift_pix(6'($urandom_range(0, 63)));
      strobe(a, 1'b0);
      if ($urandom_range(0, 3) == 0) strobe(a, 1'b0);
      wait_drain();
    end
    rand_ready = 1'b0;
    tick(1);
    out_ready = 1'b1;
    check("random_overrun", overrun_cnt, m_ovr);

`ifdef HUB75_RX_OE_MEASURE_EN
    do_reset();
    strobe(5'd1, 1'b0);
    wait_drain();
    pin_oe = 1'b0;
    tick(37);
    pin_oe = 1'b1;
    tick(2);
    strobe(5'd1, 1'b0);
    check("oe_cycles_37", oe_cycles, 37);
    wait_drain();
`else
    check("oe_cycles_off", oe_cycles, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
